// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA timing bundle between the sync generator and the pixel renderer
interface vga_sync_gen_if;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       line_start;
   logic       frame_start;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   modport master (
      output h_cnt, v_cnt, hsync, vsync, video_on, line_start, frame_start
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
      , output frame_cnt
`endif
   );

   modport slave (
      input h_cnt, v_cnt, hsync, vsync, video_on, line_start, frame_start
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
      , input frame_cnt
`endif
   );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel timing generator advanced by pix_tick
// Optional frames-started counter on the interface: VGA_SYNC_GEN_FRAME_CNT_EN
module vga_sync_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic           org_clk,
   input  logic           sys_rst_n,
   input  logic           pix_tick,
   vga_sync_gen_if.master vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_sync_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_sync_gen: V_TOTAL exceeds 1024");
   end

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FP_AT = 10'(H_ACTIVE);
   localparam logic [9:0] H_SY_AT = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_AT = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FP_AT = 10'(V_ACTIVE);
   localparam logic [9:0] V_SY_AT = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_AT = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_t;

   phase_t     h_state, h_state_nxt;
   phase_t     v_state, v_state_nxt;
   logic [9:0] h_cnt_q, v_cnt_q;
   logic [9:0] h_nxt, v_nxt;
   logic       h_wrap, f_wrap;
   logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

   assign h_wrap = pix_tick && (h_cnt_q == H_LAST);
   assign f_wrap = h_wrap && (v_cnt_q == V_LAST);

   always_comb begin
      h_nxt = h_cnt_q;
      v_nxt = v_cnt_q;
      if (pix_tick) begin
         if (h_wrap) begin
            h_nxt = '0;
            v_nxt = f_wrap ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_nxt = h_cnt_q + 10'd1;
         end
      end
   end

   // Phases step on the boundary the next counter value lands on, so the
   // registered decodes line up with the counters they accompany.
   always_comb begin
      h_state_nxt = h_state;
      if (pix_tick) begin
         case (h_state)
            PH_ACTIVE: if (h_nxt == H_FP_AT) h_state_nxt = PH_FP;
            PH_FP:     if (h_nxt == H_SY_AT) h_state_nxt = PH_SYNC;
            PH_SYNC:   if (h_nxt == H_BP_AT) h_state_nxt = PH_BP;
            PH_BP:     if (h_nxt == 10'd0)   h_state_nxt = PH_ACTIVE;
            default:   h_state_nxt = PH_BP;
         endcase
      end
   end

   always_comb begin
      v_state_nxt = v_state;
      if (h_wrap) begin
         case (v_state)
            PH_ACTIVE: if (v_nxt == V_FP_AT) v_state_nxt = PH_FP;
            PH_FP:     if (v_nxt == V_SY_AT) v_state_nxt = PH_SYNC;
            PH_SYNC:   if (v_nxt == V_BP_AT) v_state_nxt = PH_BP;
            PH_BP:     if (v_nxt == 10'd0)   v_state_nxt = PH_ACTIVE;
            default:   v_state_nxt = PH_BP;
         endcase
      end
   end

   always_ff @(posedge org_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_state       <= PH_BP;
         v_state       <= PH_BP;
         h_cnt_q       <= H_LAST;
         v_cnt_q       <= V_LAST;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_state       <= h_state_nxt;
         v_state       <= v_state_nxt;
         h_cnt_q       <= h_nxt;
         v_cnt_q       <= v_nxt;
         hsync_q       <= (h_state_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
         vsync_q       <= (v_state_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
         video_on_q    <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
         line_start_q  <= h_wrap;
         frame_start_q <= f_wrap;
      end
   end

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge org_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_cnt_q <= '0;
      end else if (f_wrap) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign vid.frame_cnt = frame_cnt_q;
`endif

   assign vid.h_cnt       = h_cnt_q;
   assign vid.v_cnt       = v_cnt_q;
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.video_on    = video_on_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen on a reduced 16x10 raster
module tb_vga_sync_gen;
   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 6, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic org_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic pix_tick = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   vga_sync_gen_if vid ();

   vga_sync_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .org_clk  (org_clk),
      .sys_rst_n(sys_rst_n),
      .pix_tick (pix_tick),
      .vid      (vid)
   );

   always #5 org_clk = ~org_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge org_clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_h"}, 32'(vid.h_cnt), HT - 1);
      chk({pfx, "_v"}, 32'(vid.v_cnt), VT - 1);
      chk({pfx, "_video_on"}, 32'(vid.video_on), 0);
      chk({pfx, "_hsync"}, 32'(vid.hsync), 1);
      chk({pfx, "_vsync"}, 32'(vid.vsync), 1);
      chk({pfx, "_line_start"}, 32'(vid.line_start), 0);
      chk({pfx, "_frame_start"}, 32'(vid.frame_start), 0);
   endtask

   initial begin
      int mh, mv, n_line, n_frame, n_vid, bad_pos, bad_hs, bad_vs, bad_vo;
      int f0, f1, l0, l1;
      bit found;

      // Reset and hold with no ticks
      repeat (3) step();
      sys_rst_n = 1'b1;
      chk_reset_vals("rst");
      repeat (100) step();
      chk_reset_vals("hold");

      // First tick wraps to the origin
      pix_tick = 1'b1;
      step();
      pix_tick = 1'b0;
      chk("t1_h", 32'(vid.h_cnt), 0);
      chk("t1_v", 32'(vid.v_cnt), 0);
      chk("t1_video_on", 32'(vid.video_on), 1);
      chk("t1_hsync", 32'(vid.hsync), 1);
      chk("t1_line_start", 32'(vid.line_start), 1);
      chk("t1_frame_start", 32'(vid.frame_start), 1);
      step();
      chk("t1_line_start_clr", 32'(vid.line_start), 0);
      chk("t1_frame_start_clr", 32'(vid.frame_start), 0);
      chk("t1_h_hold", 32'(vid.h_cnt), 0);

      // One full frame with pix_tick held high
      mh = 0; mv = 0;
      n_line = 0; n_frame = 0; n_vid = 0;
      bad_pos = 0; bad_hs = 0; bad_vs = 0; bad_vo = 0;
      pix_tick = 1'b1;
      for (int i = 0; i < HT * VT; i++) begin
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
         step();
         if (int'(vid.h_cnt) != mh || int'(vid.v_cnt) != mv) bad_pos++;
         if (vid.hsync !== ((mh >= HA + HF && mh < HA + HF + HS) ? 1'b0 : 1'b1)) bad_hs++;
         if (vid.vsync !== ((mv >= VA + VF && mv < VA + VF + VS) ? 1'b0 : 1'b1)) bad_vs++;
         if (vid.video_on !== ((mh < HA && mv < VA) ? 1'b1 : 1'b0)) bad_vo++;
         if (vid.line_start) n_line++;
         if (vid.frame_start) n_frame++;
         if (vid.video_on) n_vid++;
      end
      pix_tick = 1'b0;
      chk("frame_pos_errs", bad_pos, 0);
      chk("frame_hsync_errs", bad_hs, 0);
      chk("frame_vsync_errs", bad_vs, 0);
      chk("frame_video_on_errs", bad_vo, 0);
      chk("frame_line_starts", n_line, VT);
      chk("frame_frame_starts", n_frame, 1);
      chk("frame_video_cycles", n_vid, HA * VA);
      chk("frame_end_h", 32'(vid.h_cnt), 0);
      chk("frame_end_v", 32'(vid.v_cnt), 0);

      // Divide-by-4 tick cadence
      f0 = -1; f1 = -1; l0 = -1; l1 = -1;
      for (int c = 0; c < 1400; c++) begin
         pix_tick = (c % 4 == 0);
         step();
         if (vid.frame_start) begin
            if (f0 < 0) f0 = c; else if (f1 < 0) f1 = c;
         end
         if (vid.line_start) begin
            if (l0 < 0) l0 = c; else if (l1 < 0) l1 = c;
         end
      end
      pix_tick = 1'b0;
      chk("div4_frame_period", f1 - f0, HT * VT * 4);
      chk("div4_line_spacing", l1 - l0, HT * 4);

      // Asynchronous reset mid-frame
      found = 1'b0;
      pix_tick = 1'b1;
      for (int c = 0; c < 2 * HT * VT && !found; c++) begin
         step();
         if (vid.h_cnt == 10'd5 && vid.v_cnt == 10'd3) found = 1'b1;
      end
      pix_tick = 1'b0;
      chk("mid_reach", 32'(found), 1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      #1 sys_rst_n = 1'b1;
      pix_tick = 1'b1;
      step();
      pix_tick = 1'b0;
      chk("mid_frame_start", 32'(vid.frame_start), 1);
      chk("mid_h", 32'(vid.h_cnt), 0);
      chk("mid_v", 32'(vid.v_cnt), 0);

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
      begin
         int bad_fc;
         logic [15:0] prev;
         sys_rst_n = 1'b0;
         step();
         sys_rst_n = 1'b1;
         chk("fc_reset", 32'(vid.frame_cnt), 0);
         bad_fc = 0;
         prev = vid.frame_cnt;
         pix_tick = 1'b1;
         for (int i = 0; i < 3 * HT * VT; i++) begin
            step();
            if (vid.frame_cnt !== prev + 16'(vid.frame_start)) bad_fc++;
            prev = vid.frame_cnt;
         end
         pix_tick = 1'b0;
         chk("fc_step_errs", bad_fc, 0);
         chk("fc_three", 32'(vid.frame_cnt), 3);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator for the VGA path. It consumes the one-`org_clk`-wide pixel strobe produced by the clock-divider stage on `pix_tick`, and advances horizontal/vertical position counters once per strobe. It produces registered `hsync`, `vsync`, `video_on`, the current pixel coordinates, and line/frame start pulses for the downstream pixel renderer. Everything runs in the `org_clk` domain; `pix_tick` is a clock enable, never a clock.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, active level of `hsync`
- `VS_POL`, 0, active level of `vsync`

Ports:
- `org_clk` in 1: system clock
- `sys_rst_n` in 1: asynchronous, active-low reset
- `pix_tick` in 1: pixel-advance strobe from the divider; one `org_clk` wide, or held high
- `h_cnt` out 10: current pixel column, 0..H_TOTAL-1
- `v_cnt` out 10: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync at `HS_POL` polarity
- `vsync` out 1: vertical sync at `VS_POL` polarity
- `video_on` out 1: high when `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`
- `line_start` out 1: one-`org_clk` pulse when `h_cnt` becomes 0
- `frame_start` out 1: one-`org_clk` pulse when (`h_cnt`, `v_cnt`) becomes (0,0)
- `frame_cnt` out 16: frames started since reset; present only with `VGA_SYNC_GEN_FRAME_CNT_EN`

## Operation

- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; exceeding that limit is a configuration error and triggers an elaboration-time `$error`.
- Horizontal phase FSM, with states ACTIVE → FP → SYNC → BP → ACTIVE:
  - Transitions happen only on `pix_tick`, at `h_cnt` boundaries H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and H_TOTAL (wrap to 0).
  - The vertical FSM has the same four states. It steps once per line wrap, at the equivalent `v_cnt` boundaries.
- Counter advance on each `pix_tick`:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At V_TOTAL-1, `v_cnt` wraps to 0.
- `hsync`/`vsync` are active while the corresponding FSM is in SYNC (hsync: `h_cnt` 656..751; vsync: `v_cnt` 490..491 at defaults).
- `hsync`, `vsync`, `video_on`, `line_start` and `frame_start` are registered. They are decoded from the next counter values, so they are always consistent with `h_cnt`/`v_cnt` in the same cycle.
- Without `pix_tick`, all outputs hold, except `line_start` and `frame_start`, which are 0.
- Reset state: `h_cnt`=H_TOTAL-1, `v_cnt`=V_TOTAL-1 (vertical BP, horizontal BP).
  - Reset values: `video_on`=0, `hsync`=~HS_POL, `vsync`=~VS_POL, `line_start`=0, `frame_start`=0, `frame_cnt`=0.
  - The first `pix_tick` after reset wraps to (0,0) and asserts `line_start` and `frame_start`.
- An asynchronous reset asserted mid-frame immediately forces the reset state. There is no partial-line recovery.

## Timing

- Latency: outputs update in the `org_clk` cycle after the edge that samples `pix_tick`=1.
- `line_start` and `frame_start` are exactly one `org_clk` wide, even when `pix_tick` is held high.
- `pix_tick` held high continuously advances one pixel per `org_clk` (divide-by-1 operation).
- One frame = H_TOTAL×V_TOTAL ticks = 420000 at defaults. With a tick every N clocks, a frame is 420000×N `org_clk` cycles.
- Wrap at (H_TOTAL-1, V_TOTAL-1): `h_cnt`, `v_cnt`, both FSMs, `line_start` and `frame_start` all change in the same cycle.

## Configuration

- `VGA_SYNC_GEN_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments in the same cycle `frame_start` asserts.
  - It wraps 65535→0.
- Not defined: `frame_cnt` port and its register are absent. All other behaviour is identical.

## Test plan

- Reset with `pix_tick`=0 → `h_cnt`=799, `v_cnt`=524, `video_on`=0, `hsync`=`vsync`=1 (defaults); outputs hold for 100 clocks.
- Single `pix_tick` after reset → next cycle `h_cnt`=0, `v_cnt`=0, `video_on`=1, `line_start`=`frame_start`=1 for exactly one clock.
- `pix_tick` held high for one full frame → exactly 525 `line_start` pulses and 1 `frame_start`; `hsync` low only for `h_cnt` 656..751; `vsync` low only for `v_cnt` 490..491; `video_on` high for 307200 cycles.
- `pix_tick` every 4th clock (divide-by-4) → frame period 1680000 `org_clk`; `line_start` spacing 3200 clocks.
- Assert `sys_rst_n` low at (`h_cnt`=300, `v_cnt`=200) → outputs immediately return to reset values; the next tick produces `frame_start`.
- With `VGA_SYNC_GEN_FRAME_CNT_EN`, run 3 frames → `frame_cnt`=3, incrementing exactly on `frame_start`.
